morph_line_sched: RTL and testbench
===================================

Name: morph_line_sched

Overview:
- Controller that sequences the single-port line-buffer BRAM and row registers of the 3x3 erode/dilate datapath.
- Once per frame, primes three window rows from BRAM.
- Per active line, gates pixel capture and window output, then uses horizontal blanking for two BRAM accesses:
  - writeback of the captured line;
  - fetch of the next window row.
- Sits between the VGA/NTSC timing generator (hcount/vcount) and the morphology datapath; owns the BRAM address and write-enable exclusively.

Parameters:
LINE_W, 528, active pixels per line; also the hcount at which blanking work starts
NUM_LINES, 480, active lines per frame
ADDR_W, 10, BRAM address width; requires 2^ADDR_W >= NUM_LINES

Ports:
clk  in  1  system pixel clock
reset_n  in  1  asynchronous active-low reset
hcount  in  11  horizontal pixel counter from timing generator
vcount  in  10  vertical line counter from timing generator
enable  in  1  run request; sampled at frame start
bram_addr  out  ADDR_W  line-buffer address
bram_we  out  1  line-buffer write strobe (one cycle)
load_sel  out  2  prime load target, one cycle after the read address: 0 none, 1 row1, 2 row2, 3 row3
shift_rows  out  1  one-cycle pulse: row1<=row2, row2<=row3, row3<=BRAM dout
capture_en  out  1  datapath stores the current pixel into the line register
window_valid  out  1  datapath output window is valid (else output color 0)
busy  out  1  high in every state except IDLE
frame_done  out  1  one-cycle pulse after last-line writeback

Behaviour:
- Reset (async, reset_n=0): state IDLE; all outputs 0; line_ptr=0. Takes effect immediately, mid-access included; no partial write completes after reset asserts.
- BRAM read latency is 1 cycle. Write and read never share a cycle; bram_we=1 only in WRITE.
- States: IDLE, PRIME, WAIT_LINE, ACTIVE, WRITE, FETCH, SHIFT.
- IDLE: enable=1 and hcount==0 and vcount==0 -> PRIME.
- PRIME: 4 cycles; cycle k=0..2 drives bram_addr=k; load_sel = 1,2,3 on cycles 1..3; then line_ptr=0 -> WAIT_LINE.
- WAIT_LINE: hcount==0 and vcount==line_ptr -> ACTIVE.
- ACTIVE:
  - capture_en=1 for hcount in 0..LINE_W-1.
  - window_valid is registered (1-cycle latency, aligned with the datapath's registered color).
  - window_valid=1 iff hcount in 1..LINE_W-2 and line_ptr in 1..NUM_LINES-2.
  - hcount==LINE_W -> WRITE.
- WRITE: one cycle; bram_addr=line_ptr, bram_we=1 -> FETCH.
- FETCH:
  - If line_ptr+3 < NUM_LINES: bram_addr=line_ptr+3 -> SHIFT.
  - Otherwise no read and no shift -> line advance.
- SHIFT: shift_rows=1 for one cycle -> line advance.
- Line advance:
  - If line_ptr==NUM_LINES-1: frame_done=1 for one cycle -> IDLE.
  - Else line_ptr+1 -> WAIT_LINE; if enable==0 -> IDLE without frame_done.
- Width rules: line_ptr+3 computed at ADDR_W+1 bits (no wrap); bram_addr never exceeds NUM_LINES-1.
- Timing constraint: blanking after LINE_W must be >= 4 cycles; a shorter blanking is a system error.
- Restart: hcount==0 and vcount==0 in any non-IDLE state other than PRIME -> PRIME immediately. No frame_done; any in-progress WRITE is abandoned.
- hcount/vcount values beyond active range: no effect except the transitions listed above.
- enable deassert mid-line: the current line completes, including WRITE/FETCH/SHIFT, then IDLE.

Test Plan:
- Reset: reset_n=0 mid-ACTIVE -> all outputs 0 in the same cycle; after release, busy=0 until the next (0,0) with enable=1.
- Frame start: enable=1, (h,v)=(0,0) -> bram_addr 0,1,2 on cycles 1-3; load_sel 1,2,3 on cycles 2-4; busy=1.
- Line 5: capture_en high for hcount 0..527; window_valid high one cycle later for hcount 1..526. At hcount 528: bram_we=1 with addr 5; then addr 8 read; then shift_rows pulse.
- Last lines: line 477 -> no read and no shift_rows. Line 479 -> WRITE at addr 479, frame_done pulse, busy=0.
- Mid-frame (0,0) at line 200 -> PRIME restarts at addr 0; no frame_done.
- enable=0 during line 10 -> line 10 writeback and fetch complete, then IDLE; line 11 produces no capture_en.

Source files
------------

// File: rtl/morph_line_sched_if.sv
// Timing inputs and line-buffer / datapath control outputs of morph_line_sched.
// master = scheduler side, slave = timing generator plus datapath side; no backpressure.
interface morph_line_sched_if #(
  parameter int ADDR_W = 10
);
  logic [10:0]       hcount;
  logic [9:0]        vcount;
  logic              enable;
  logic [ADDR_W-1:0] bram_addr;
  logic              bram_we;
  logic [1:0]        load_sel;
  logic              shift_rows;
  logic              capture_en;
  logic              window_valid;
  logic              busy;
  logic              frame_done;

  modport master (
    input  hcount, vcount, enable,
    output bram_addr, bram_we, load_sel, shift_rows,
    output capture_en, window_valid, busy, frame_done
  );

  modport slave (
    output hcount, vcount, enable,
    input  bram_addr, bram_we, load_sel, shift_rows,
    input  capture_en, window_valid, busy, frame_done
  );
endinterface

// File: rtl/morph_line_sched.sv
// Line-buffer BRAM and row-register sequencer for the 3x3 erode/dilate window.
// BRAM controls registered (1-cycle read latency assumed); no backpressure, timing generator paces everything.
module morph_line_sched #(
  parameter int LINE_W    = 528,
  parameter int NUM_LINES = 480,
  parameter int ADDR_W    = 10
) (
  input  logic                clk,
  input  logic                reset_n,
  morph_line_sched_if.master  bus
);
  typedef enum logic [2:0] {IDLE, PRIME, WAIT_LINE, ACTIVE, WRITE, FETCH, SHIFT} state_t;

  localparam logic [10:0]       H_END         = 11'(LINE_W);
  localparam logic [10:0]       H_WIN_LAST    = 11'(LINE_W - 2);
  localparam logic [ADDR_W-1:0] LAST_LINE     = ADDR_W'(NUM_LINES - 1);
  localparam logic [ADDR_W-1:0] WIN_LINE_LAST = ADDR_W'(NUM_LINES - 2);
  localparam logic [ADDR_W:0]   NUM_LINES_X   = (ADDR_W + 1)'(NUM_LINES);

  state_t            state;
  logic [ADDR_W-1:0] line_ptr;
  logic [1:0]        prime_cnt;
  logic [ADDR_W-1:0] addr_q;
  logic              we_q;
  logic [1:0]        load_q;
  logic              shift_q;
  logic              wv_q;
  logic              done_q;

  logic              frame_origin;
  logic              line_start;
  logic              restart;
  logic              fetch_ok;
  logic              advance;
  logic              win_next;
  logic [ADDR_W:0]   fetch_line;

  assign frame_origin = (bus.hcount == 11'd0) && (bus.vcount == 10'd0);
  assign line_start   = (bus.hcount == 11'd0) && (32'(bus.vcount) == 32'(line_ptr));
  // Line 0 begins on the frame origin itself, so waiting for it is not a restart.
  assign restart      = frame_origin && !(state inside {IDLE, PRIME}) &&
                        !(state == WAIT_LINE && line_ptr == '0);
  assign fetch_line   = {1'b0, line_ptr} + (ADDR_W + 1)'(3);
  assign fetch_ok     = fetch_line < NUM_LINES_X;
  assign advance      = (state == SHIFT) || (state == FETCH && !fetch_ok);
  assign win_next     = (state == ACTIVE) &&
                        (bus.hcount >= 11'd1) && (bus.hcount <= H_WIN_LAST) &&
                        (line_ptr >= ADDR_W'(1)) && (line_ptr <= WIN_LINE_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      line_ptr  <= '0;
      prime_cnt <= 2'd0;
      addr_q    <= '0;
      we_q      <= 1'b0;
      load_q    <= 2'd0;
      shift_q   <= 1'b0;
      wv_q      <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      we_q    <= 1'b0;
      shift_q <= 1'b0;
      load_q  <= 2'd0;
      done_q  <= 1'b0;
      addr_q  <= '0;
      wv_q    <= win_next;
      if (restart) begin
        state     <= PRIME;
        prime_cnt <= 2'd0;
      end else begin
        case (state)
          IDLE: begin
            if (bus.enable && frame_origin) begin
              state     <= PRIME;
              prime_cnt <= 2'd0;
            end
          end
          PRIME: begin
            if (prime_cnt == 2'd3) begin
              state    <= WAIT_LINE;
              line_ptr <= '0;
            end else begin
              prime_cnt <= prime_cnt + 2'd1;
              load_q    <= prime_cnt + 2'd1;
              if (prime_cnt != 2'd2) addr_q <= ADDR_W'(prime_cnt) + ADDR_W'(1);
            end
          end
          WAIT_LINE: if (line_start) state <= ACTIVE;
          ACTIVE: begin
            if (bus.hcount == H_END) begin
              state  <= WRITE;
              we_q   <= 1'b1;
              addr_q <= line_ptr;
            end
          end
          WRITE: begin
            state <= FETCH;
            if (fetch_ok) addr_q <= fetch_line[ADDR_W-1:0];
          end
          FETCH: begin
            if (fetch_ok) begin
              state   <= SHIFT;
              shift_q <= 1'b1;
            end
          end
          SHIFT: begin
          end
          default: state <= IDLE;
        endcase
        // Line advance overrides the per-state next state above.
        if (advance) begin
          if (line_ptr == LAST_LINE) begin
            done_q <= 1'b1;
            state  <= IDLE;
          end else if (!bus.enable) begin
            state <= IDLE;
          end else begin
            line_ptr <= line_ptr + ADDR_W'(1);
            state    <= WAIT_LINE;
          end
        end
      end
    end
  end

  assign bus.bram_addr    = addr_q;
  assign bus.bram_we      = we_q;
  assign bus.load_sel     = load_q;
  assign bus.shift_rows   = shift_q;
  assign bus.window_valid = wv_q;
  assign bus.frame_done   = done_q;
  assign bus.busy         = (state != IDLE);
  assign bus.capture_en   = ((state == ACTIVE) && (bus.hcount < H_END)) ||
                            ((state == WAIT_LINE) && line_start);
endmodule

// File: tb/tb_morph_line_sched.sv
// Randomized line/frame stimulus checked against a per-line transaction model of the scheduler.
module tb_morph_line_sched;
  localparam int LINE_W    = 528;
  localparam int NUM_LINES = 480;
  localparam int ADDR_W    = 10;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  morph_line_sched_if #(.ADDR_W(ADDR_W)) bus();

  morph_line_sched #(
    .LINE_W(LINE_W), .NUM_LINES(NUM_LINES), .ADDR_W(ADDR_W)
  ) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  bit en_drv  = 1'b0;
  bit running = 1'b0;

  task automatic check(input string tag, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // One pixel-clock cycle: drive inputs just after the edge, return at the falling edge.
  task automatic cyc(input int h, input int v);
    @(posedge clk);
    #1;
    bus.hcount = 11'(h);
    bus.vcount = 10'(v);
    bus.enable = en_drv;
    @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_addr"}, int'(bus.bram_addr), 0);
    check({tag, "_we"}, int'(bus.bram_we), 0);
    check({tag, "_load"}, int'(bus.load_sel), 0);
    check({tag, "_shift"}, int'(bus.shift_rows), 0);
    check({tag, "_cap"}, int'(bus.capture_en), 0);
    check({tag, "_wv"}, int'(bus.window_valid), 0);
    check({tag, "_busy"}, int'(bus.busy), 0);
    check({tag, "_done"}, int'(bus.frame_done), 0);
  endtask

  task automatic check_blank(input string tag);
    check({tag, "_cap"}, int'(bus.capture_en), 0);
    check({tag, "_we"}, int'(bus.bram_we), 0);
    check({tag, "_shift"}, int'(bus.shift_rows), 0);
    check({tag, "_wv"}, int'(bus.window_valid), 0);
    check({tag, "_busy"}, int'(bus.busy), int'(running));
  endtask

  // Frame origin followed by the four priming cycles.
  task automatic do_prime(input bit from_idle);
    cyc(0, 0);
    check("prime_entry_busy", int'(bus.busy), from_idle ? 0 : 1);
    for (int k = 1; k <= 5; k++) begin
      cyc(k, 0);
      check("prime_busy", int'(bus.busy), 1);
      check("prime_load", int'(bus.load_sel), (k <= 4) ? k - 1 : 0);
      if (k <= 3) check("prime_addr", int'(bus.bram_addr), k - 1);
      check("prime_we", int'(bus.bram_we), 0);
      check("prime_shift", int'(bus.shift_rows), 0);
      check("prime_done", int'(bus.frame_done), 0);
    end
    running = 1'b1;
  endtask

  function automatic int win_exp(input int prev_h, input int line);
    return int'(prev_h >= 1 && prev_h <= LINE_W - 2 && line >= 1 && line <= NUM_LINES - 2);
  endfunction

  task automatic run_line(input int line, input bit full, input bit drop);
    bit last;
    bit fok;
    int h;
    int prev;
    last = (line == NUM_LINES - 1);
    fok  = (line + 3 < NUM_LINES);
    h    = 0;
    prev = -1;
    while (h < LINE_W) begin
      if (drop && h > 0) en_drv = 1'b0;
      cyc(h, line);
      check("line_cap", int'(bus.capture_en), 1);
      check("line_wv", int'(bus.window_valid), win_exp(prev, line));
      check("line_busy", int'(bus.busy), 1);
      check("line_we", int'(bus.bram_we), 0);
      prev = h;
      h += full ? 1 : int'($urandom_range(1, 120));
    end
    cyc(LINE_W, line);
    check("end_cap", int'(bus.capture_en), 0);
    check("end_wv", int'(bus.window_valid), win_exp(prev, line));
    check("end_we", int'(bus.bram_we), 0);
    cyc(LINE_W + 1, line);
    check("wb_we", int'(bus.bram_we), 1);
    check("wb_addr", int'(bus.bram_addr), line);
    check("wb_wv", int'(bus.window_valid), 0);
    check("wb_shift", int'(bus.shift_rows), 0);
    cyc(LINE_W + 2, line);
    check("fetch_we", int'(bus.bram_we), 0);
    check("fetch_shift", int'(bus.shift_rows), 0);
    if (fok) check("fetch_addr", int'(bus.bram_addr), line + 3);
    cyc(LINE_W + 3, line);
    check("shift_pulse", int'(bus.shift_rows), int'(fok));
    check("shift_we", int'(bus.bram_we), 0);
    if (fok) begin
      check("shift_done", int'(bus.frame_done), 0);
      cyc(LINE_W + 4, line);
      check("post_shift", int'(bus.shift_rows), 0);
    end
    running = !(last || !en_drv);
    check("adv_done", int'(bus.frame_done), int'(last));
    check("adv_busy", int'(bus.busy), int'(running));
    repeat ($urandom_range(0, 3)) begin
      cyc($urandom_range(LINE_W + 5, 1500), $urandom_range(0, 1023));
      check_blank("blank");
    end
  endtask

  initial begin
    bus.hcount = '0;
    bus.vcount = '0;
    bus.enable = 1'b0;
    repeat (2) @(negedge clk);
    check_all_zero("rst");
    #2 reset_n = 1'b1;

    cyc(700, 5);
    check_blank("idle");

    // Frame A: full-length line 5, enable dropped during line 10.
    en_drv = 1'b1;
    do_prime(1'b1);
    for (int l = 0; l <= 10; l++) run_line(l, l == 5, l == 10);
    cyc(0, 11);
    check_blank("after_drop");

    // Frame B: frame origin arrives in the middle of line 200.
    en_drv = 1'b1;
    do_prime(1'b1);
    for (int l = 0; l < 200; l++) run_line(l, 1'b0, 1'b0);
    for (int h = 0; h < 3; h++) begin
      cyc(h, 200);
      check("l200_cap", int'(bus.capture_en), 1);
    end
    do_prime(1'b0);

    // Frame C: every line through the final writeback.
    for (int l = 0; l < NUM_LINES; l++) run_line(l, l == 1 || l == NUM_LINES - 2, 1'b0);

    // Frame D: asynchronous reset inside an active line.
    do_prime(1'b1);
    for (int l = 0; l < 5; l++) run_line(l, 1'b0, 1'b0);
    for (int h = 0; h < 3; h++) cyc(h, 5);
    check("pre_rst_wv", int'(bus.window_valid), 1);
    check("pre_rst_cap", int'(bus.capture_en), 1);
    #1 reset_n = 1'b0;
    #1 check_all_zero("async_rst");
    #1 reset_n = 1'b1;
    running = 1'b0;
    cyc(3, 5);
    check_blank("post_rst");
    cyc(0, 6);
    check_blank("post_rst_l6");
    en_drv = 1'b0;
    cyc(0, 0);
    cyc(1, 0);
    check_blank("origin_no_en");
    check("origin_no_en_load", int'(bus.load_sel), 0);
    en_drv = 1'b1;
    do_prime(1'b1);
    run_line(0, 1'b0, 1'b0);
    run_line(1, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
